// File: rtl/sad_pkg.sv
// Shared types and sizing helpers for the SAD accumulator datapath.
package sad_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width that holds BLOCK_LEN * (2^DATA_W - 1) without overflow.
   function automatic int unsigned sad_w(input int unsigned block_len);
      return DATA_W + $clog2(block_len);
   endfunction

endpackage

// File: rtl/sklansky_sub_8bit.sv
// Combinational a - b as a + ~b + 1 on a Sklansky prefix tree; carry-in sits at prefix position 0.
module sklansky_sub_8bit
   import sad_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] diff,
   output logic              carry_out
);

   localparam int unsigned N     = DATA_W + 1;
   localparam int unsigned LVLS  = $clog2(N);
   localparam int unsigned IDX_W = $clog2(N);

   logic [DATA_W-1:0] w_p_bit;
   logic [N-1:0]      w_g;
   logic [N-1:0]      w_p;

   assign w_p_bit = a ^ ~b;

   // Groups that already reach position 0 only need G (gray cell); their P is 0 because
   // the carry-in position never propagates.
   always_comb begin : p_prefix
      int k;
      k   = 0;
      w_g = {a & ~b, 1'b1};
      w_p = {w_p_bit, 1'b0};
      for (int l = 0; l < int'(LVLS); l++) begin
         for (int j = 0; j < int'(N); j++) begin
            if (((j >> l) & 1) == 1) begin
               k = ((j >> l) << l) - 1;
               w_g[IDX_W'(j)] = w_g[IDX_W'(j)] | (w_p[IDX_W'(j)] & w_g[IDX_W'(k)]);
               if (j < (2 << l)) begin
                  w_p[IDX_W'(j)] = 1'b0;
               end else begin
                  w_p[IDX_W'(j)] = w_p[IDX_W'(j)] & w_p[IDX_W'(k)];
               end
            end
         end
      end
   end

   assign diff      = w_p_bit ^ w_g[DATA_W-1:0];
   assign carry_out = w_g[DATA_W];

endmodule

// File: rtl/sklansky_sad_accum.sv
// Block sum-of-absolute-differences: prefix subtractor, abs stage, accumulator and
// a RUN/FLUSH/DONE controller presenting each block result over valid/ready.
module sklansky_sad_accum
   import sad_pkg::*;
#(
   parameter int unsigned BLOCK_LEN = 16,
   parameter int unsigned SAD_W     = sad_w(BLOCK_LEN)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [DATA_W-1:0]            a,
   input  logic [DATA_W-1:0]            b,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         clear,
   output logic [SAD_W-1:0]             sad,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(BLOCK_LEN)-1:0] sample_cnt
);

   localparam int unsigned      CNT_W    = $clog2(BLOCK_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   if (BLOCK_LEN < 2 || (BLOCK_LEN & (BLOCK_LEN - 1)) != 0) begin : g_bad_block_len
      $error("BLOCK_LEN must be a power of two and at least 2");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] w_diff;
   logic              w_carry;
   logic [DATA_W-1:0] r_diff;
   logic              r_borrow;
   logic              r_s1_valid;
   logic              r_s1_last;
   logic [DATA_W-1:0] w_abs;
   logic [SAD_W-1:0]  w_acc_sum;
   logic [SAD_W-1:0]  r_acc;
   logic [SAD_W-1:0]  r_sad;
   logic              r_out_valid;

   sklansky_sub_8bit u_sub (
      .a         (a),
      .b         (b),
      .diff      (w_diff),
      .carry_out (w_carry)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // clear overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && !clear) begin
               w_accept = 1'b1;
               if (r_cnt == CNT_LAST) begin
                  w_state_nxt = FLUSH;
               end
            end
         end
         FLUSH: w_state_nxt = DONE;
         DONE: begin
            if (out_ready) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = RUN;
      endcase
      if (clear) begin
         w_state_nxt = RUN;
      end
   end

   assign w_abs     = r_borrow ? DATA_W'(~r_diff + DATA_W'(1)) : r_diff;
   assign w_acc_sum = r_acc + SAD_W'(w_abs);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_acc       <= '0;
         r_sad       <= '0;
         r_out_valid <= 1'b0;
      end else if (clear) begin
         r_cnt       <= '0;
         r_s1_valid  <= 1'b0;
         r_acc       <= '0;
         r_sad       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_diff    <= w_diff;
            r_borrow  <= ~w_carry;
            r_s1_last <= (r_cnt == CNT_LAST);
            r_cnt     <= CNT_W'(r_cnt + CNT_W'(1));
         end
         // Final sample of a block lands in sad; the accumulator restarts from zero.
         if (r_s1_valid) begin
            if (r_s1_last) begin
               r_sad       <= w_acc_sum;
               r_acc       <= '0;
               r_out_valid <= 1'b1;
            end else begin
               r_acc <= w_acc_sum;
            end
         end
         if (r_state == DONE && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign sad        = r_sad;
   assign out_valid  = r_out_valid;
   assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_sklansky_sad_accum.sv
// Directed bench for sklansky_sad_accum with a 4-sample and a 16-sample instance.
module tb_sklansky_sad_accum;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        out_ready;
   logic        in_valid4;
   logic        in_valid16;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        in_ready4;
   logic        out_valid4;
   logic [9:0]  sad4;
   logic [1:0]  cnt4;
   logic        in_ready16;
   logic        out_valid16;
   logic [11:0] sad16;
   logic [3:0]  cnt16;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sklansky_sad_accum #(.BLOCK_LEN(4)) u_dut4 (
      .clock      (clock),
      .reset_n    (reset_n),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid4),
      .in_ready   (in_ready4),
      .clear      (clear),
      .sad        (sad4),
      .out_valid  (out_valid4),
      .out_ready  (out_ready),
      .sample_cnt (cnt4)
   );

   sklansky_sad_accum #(.BLOCK_LEN(16)) u_dut16 (
      .clock      (clock),
      .reset_n    (reset_n),
      .a          (a),
      .b          (b),
      .in_valid   (in_valid16),
      .in_ready   (in_ready16),
      .clear      (clear),
      .sad        (sad16),
      .out_valid  (out_valid16),
      .out_ready  (out_ready),
      .sample_cnt (cnt16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic feed(input bit use16, input logic [7:0] aa, input logic [7:0] bb, input int n);
      a          = aa;
      b          = bb;
      in_valid4  = !use16;
      in_valid16 = use16;
      repeat (n) step();
      in_valid4  = 1'b0;
      in_valid16 = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      clear      = 1'b0;
      out_ready  = 1'b1;
      in_valid4  = 1'b0;
      in_valid16 = 1'b0;
      a          = '0;
      b          = '0;
      repeat (2) step();
      check("rst_sad",      32'(sad4),       0);
      check("rst_ovalid",   32'(out_valid4), 0);
      check("rst_cnt",      32'(cnt4),       0);
      check("rst_in_ready", 32'(in_ready4),  1);
      reset_n = 1'b1;

      // Mixed signs and both extremes, back-to-back: 7+7+255+255.
      feed(0, 8'd10, 8'd3, 1);
      feed(0, 8'd3, 8'd10, 1);
      feed(0, 8'd255, 8'd0, 1);
      feed(0, 8'd0, 8'd255, 1);
      check("t1_cnt_wrap",   32'(cnt4),       0);
      check("t1_flush_rdy",  32'(in_ready4),  0);
      check("t1_not_yet",    32'(out_valid4), 0);
      step();
      check("t1_ovalid",     32'(out_valid4), 1);
      check("t1_sad",        32'(sad4),       524);
      step();
      check("t1_one_cycle",  32'(out_valid4), 0);
      check("t1_rdy_again",  32'(in_ready4),  1);

      // Equal inputs, then the largest possible block sum.
      feed(1, 8'h5A, 8'h5A, 16);
      step();
      check("t2_eq_ovalid",  32'(out_valid16), 1);
      check("t2_eq_sad",     32'(sad16),       0);
      step();
      feed(1, 8'd255, 8'd0, 16);
      step();
      check("t2_max_ovalid", 32'(out_valid16), 1);
      check("t2_max_sad",    32'(sad16),       4080);
      step();

      // Back-pressure: result held while in_valid stays high.
      out_ready = 1'b0;
      feed(0, 8'd1, 8'd2, 4);
      step();
      check("t3_ovalid", 32'(out_valid4), 1);
      check("t3_sad",    32'(sad4),       4);
      a         = 8'd9;
      b         = 8'd0;
      in_valid4 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_hold_rdy",  32'(in_ready4),  0);
         check("t3_hold_sad",  32'(sad4),       4);
         check("t3_hold_ovld", 32'(out_valid4), 1);
      end
      out_ready = 1'b1;
      step();
      check("t3_release_ovld", 32'(out_valid4), 0);
      check("t3_release_cnt",  32'(cnt4),       0);
      check("t3_release_rdy",  32'(in_ready4),  1);
      step();
      check("t3_next_cnt", 32'(cnt4), 1);
      repeat (3) step();
      in_valid4 = 1'b0;
      step();
      check("t3_next_sad",  32'(sad4),       36);
      check("t3_next_ovld", 32'(out_valid4), 1);
      step();

      // Bubbles between valid samples contribute nothing.
      a = 8'd7;
      b = 8'd2;
      for (int i = 0; i < 8; i++) begin
         in_valid4 = (i % 2 == 0);
         step();
      end
      in_valid4 = 1'b0;
      check("t4_ovalid", 32'(out_valid4), 1);
      check("t4_sad",    32'(sad4),       20);
      step();

      // Abort a partial block, then a fresh block must carry no residue.
      feed(0, 8'd50, 8'd0, 2);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t5_clr_cnt",  32'(cnt4),       0);
      check("t5_clr_ovld", 32'(out_valid4), 0);
      feed(0, 8'd1, 8'd0, 4);
      step();
      check("t5_sad",    32'(sad4),       4);
      check("t5_ovalid", 32'(out_valid4), 1);
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("t5_clr_sad", 32'(sad4), 0);

      // Asynchronous reset mid-block and while holding a result.
      feed(0, 8'd100, 8'd0, 2);
      check("t6_mid_cnt", 32'(cnt4), 2);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_arst_cnt",  32'(cnt4),       0);
      check("t6_arst_sad",  32'(sad4),       0);
      check("t6_arst_ovld", 32'(out_valid4), 0);
      #2;
      reset_n = 1'b1;
      feed(0, 8'd4, 8'd1, 4);
      step();
      check("t6_sad",    32'(sad4),       12);
      check("t6_ovalid", 32'(out_valid4), 1);
      out_ready = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      check("t6_done_ovld", 32'(out_valid4), 0);
      check("t6_done_sad",  32'(sad4),       0);
      check("t6_done_rdy",  32'(in_ready4),  1);
      #2;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      feed(0, 8'd0, 8'd255, 4);
      step();
      check("t6_after_sad",  32'(sad4),       1020);
      check("t6_after_ovld", 32'(out_valid4), 1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
